fib_seq_monitor: RTL and testbench
==================================

Name: fib_seq_monitor

Overview:
- Receiving end of the Fibonacci producer interface (selector in; i, n, k out).
- Passive, synthesizable monitor. Samples the producer's selector and its three 11-bit outputs every cycle.
- Runs an independent reference model and flags any departure from the producer contract.
- Placed beside the producer in simulation and in formal or property-mining harnesses; its flags are the properties checked.

Parameters:
- WIDTH, 11, width of i, n, k; all arithmetic is modulo 2^WIDTH.
- LIMIT, 21, index at which the producer restarts the sequence.
- CNT_W, 16, width of the step and error counters; counters saturate.

Ports:
- clk  input  1  rising-edge clock, shared with the producer.
- rst  input  1  asynchronous, active-low reset.
- selector  input  1  the same advance request the producer sees.
- i  input  WIDTH  producer sequence index.
- n  input  WIDTH  producer previous term.
- k  input  WIDTH  producer current term.
- err  output  1  sticky mismatch flag.
- err_code  output  3  first-failure cause: 0 none, 1 index, 2 prev term, 3 curr term, 4 hold violation.
- err_cnt  output  CNT_W  number of mismatching cycles, saturating.
- step_cnt  output  CNT_W  number of accepted advances, saturating.
- wrap_pulse  output  1  one-cycle pulse when the reference model wraps at LIMIT.

Behaviour:
- Producer contract (decided):
  - Reset state is i=0, n=0, k=1.
  - A rising clk with selector=1 and i<LIMIT gives i+1, n<=k, k<=(n+k) mod 2^WIDTH.
  - A rising clk with selector=1 and i==LIMIT restores the reset state.
  - selector=0 holds all three outputs.
- Async reset (rst=0):
  - FSM goes to SYNC.
  - Reference model is set to exp_i=0, exp_n=0, exp_k=1.
  - err=0, err_code=0, err_cnt=0, step_cnt=0, wrap_pulse=0.
- Reset mid-operation clears everything immediately, whatever the current state.
- FSM states:
  - SYNC: first cycle after reset deassert. Compares i/n/k against the reset values, then goes to TRACK.
  - TRACK: normal checking.
  - FAIL: entered on the first mismatch. Checking continues and err_cnt keeps counting; err_code stays frozen. Only reset leaves FAIL.
- Per cycle in SYNC and TRACK:
  - Compare the registered previous-cycle expectation against the current i, n, k.
  - Then update the expectation from the current selector, using the same rules as the contract.
- Checker latency:
  - Outputs update one cycle after the sample that caused them.
  - err rises the cycle after the offending values appear.
- Error priority when several fields differ in the same cycle: index > prev term > curr term.
- Hold violation (code 4): selector was 0 in the previous cycle but any of i/n/k changed. This takes priority over codes 1–3.
- Arithmetic: n+k is computed at WIDTH+1 bits and truncated; overflow is legal and not an error.
- Counters:
  - step_cnt increments on every cycle with selector=1, including the wrap cycle.
  - Both counters saturate at all-ones.
- wrap_pulse:
  - High for exactly the one cycle after the model restarts.
  - Asserted even in FAIL.
- X/Z on inputs counts as a mismatch; in simulation only the data compare applies.

Decomposition:
- Package fib_pkg holds:
  - WIDTH and LIMIT defaults.
  - FSM state enum (SYNC, TRACK, FAIL).
  - err_code constants (ERR_NONE, ERR_IDX, ERR_PREV, ERR_CURR, ERR_HOLD).
- One sub-module, fib_ref_model: holds exp_i/exp_n/exp_k and the advance/wrap logic. It is reused by the producer-side assertions.
- The top level holds the compare logic, FSM, and counters.

Test Plan:
- Golden run: reset, then selector=1 for 22 cycles against a correct producer.
  - Required: k sequence 1,1,2,3,5,…,10946 mod 2048 = 706 at i=20 (F21).
  - Required: wrap_pulse once after i=21; step_cnt=22; err=0.
- Hold: alternate selector 1/0 for 40 cycles.
  - Required: outputs held on 0-cycles; err=0; step_cnt=20.
- Injected fault: force k to 7 at i=4 (expected 5).
  - Required: next cycle err=1, err_code=3, FSM in FAIL.
  - Required: err_cnt keeps counting later mismatches; err_code stays 3.
- Hold violation: selector=0 but i changes from 3 to 4.
  - Required: err_code=4, even though the index also mismatches.
- Reset mid-run: rst low at i=10 while in FAIL.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - Required: resumes in SYNC and passes the subsequent golden run.
- Saturation with CNT_W=4: 20 advances.
  - Required: step_cnt=15, and it stays 15.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci producer monitor: default sizes,
// checker FSM states and first-failure cause codes.
package fib_pkg;

    localparam int WIDTH_DEF = 11;
    localparam int LIMIT_DEF = 21;
    localparam int CNT_W_DEF = 16;

    // Checker FSM states. The encoding is visible on dbg_state.
    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAIL  = 2'd2
    } mon_state_e;

    // First-failure cause codes reported on err_code.
    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_IDX  = 3'd1;
    localparam logic [2:0] ERR_PREV = 3'd2;
    localparam logic [2:0] ERR_CURR = 3'd3;
    localparam logic [2:0] ERR_HOLD = 3'd4;

endpackage

// File: rtl/fib_ref_model.sv
// Reference model of the Fibonacci producer: holds the expected index,
// previous term and current term, and advances them on adv_i exactly as the
// producer does. wrap_o flags the cycle whose edge restarts the sequence.
module fib_ref_model
    import fib_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LIMIT = LIMIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    output logic [WIDTH-1:0] exp_i_o,
    output logic [WIDTH-1:0] exp_n_o,
    output logic [WIDTH-1:0] exp_k_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] curr_q, curr_d;

    // Next expectation: restart at LIMIT, otherwise step the recurrence.
    // The term sum wraps modulo 2^WIDTH; overflow is part of the contract.
    always_comb begin
        wrap_o = adv_i && (idx_q == WIDTH'(LIMIT));
        idx_d  = idx_q;
        prev_d = prev_q;
        curr_d = curr_q;
        if (wrap_o) begin
            idx_d  = '0;
            prev_d = '0;
            curr_d = WIDTH'(1);
        end else if (adv_i) begin
            idx_d  = idx_q + WIDTH'(1);
            prev_d = curr_q;
            curr_d = prev_q + curr_q;
        end
    end

    // Expectation registers, reset to the producer's reset state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q  <= '0;
            prev_q <= '0;
            curr_q <= WIDTH'(1);
        end else begin
            idx_q  <= idx_d;
            prev_q <= prev_d;
            curr_q <= curr_d;
        end
    end

    assign exp_i_o = idx_q;
    assign exp_n_o = prev_q;
    assign exp_k_o = curr_q;

endmodule

// File: rtl/fib_seq_monitor.sv
// Passive monitor for the Fibonacci producer. Each cycle it compares the
// producer's i/n/k against the reference model's expectation, checks that
// outputs hold after a selector=0 cycle, and reports the first failure
// cause, a sticky error flag, saturating error/step counters and a wrap pulse.
// All outputs are registered: they reflect the sample of the previous edge.
module fib_seq_monitor
    import fib_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LIMIT = LIMIT_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             selector,
    input  logic [WIDTH-1:0] i,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] k,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] step_cnt,
    output logic             wrap_pulse,
    output logic [1:0]       dbg_state
);

    mon_state_e       state_q, state_d;
    logic [2:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic             wrap_q;
    logic             sel_prev_q;
    logic [WIDTH-1:0] i_prev_q, n_prev_q, k_prev_q;

    logic [WIDTH-1:0] exp_i, exp_n, exp_k;
    logic             model_wrap;
    logic             hold_mis, idx_mis, prev_mis, curr_mis, any_mis;
    logic [2:0]       cause;

    // The model advances on the observed selector in every state, so checking
    // carries on after the first failure.
    fib_ref_model #(
        .WIDTH (WIDTH),
        .LIMIT (LIMIT)
    ) u_ref (
        .clk     (clk),
        .rst     (rst),
        .adv_i   (selector),
        .exp_i_o (exp_i),
        .exp_n_o (exp_n),
        .exp_k_o (exp_k),
        .wrap_o  (model_wrap)
    );

    // Mismatch detection and cause priority: hold > index > prev > curr.
    // The hold check needs a real previous sample, so it is off in SYNC.
    always_comb begin
        hold_mis = (state_q != SYNC) && !sel_prev_q &&
                   ((i != i_prev_q) || (n != n_prev_q) || (k != k_prev_q));
        idx_mis  = (i != exp_i);
        prev_mis = (n != exp_n);
        curr_mis = (k != exp_k);
        any_mis  = hold_mis || idx_mis || prev_mis || curr_mis;
        cause    = ERR_NONE;
        if (hold_mis)      cause = ERR_HOLD;
        else if (idx_mis)  cause = ERR_IDX;
        else if (prev_mis) cause = ERR_PREV;
        else if (curr_mis) cause = ERR_CURR;
    end

    // FSM next state, frozen first cause and saturating counters.
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        err_cnt_d  = err_cnt_q;
        step_cnt_d = step_cnt_q;
        case (state_q)
            SYNC:    state_d = any_mis ? FAIL : TRACK;
            TRACK:   state_d = any_mis ? FAIL : TRACK;
            FAIL:    state_d = FAIL;
            default: state_d = FAIL;
        endcase
        if (state_q != FAIL && any_mis) err_code_d = cause;
        if (any_mis && !(&err_cnt_q))   err_cnt_d  = err_cnt_q + CNT_W'(1);
        if (selector && !(&step_cnt_q)) step_cnt_d = step_cnt_q + CNT_W'(1);
    end

    // Checker state and previous-sample registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SYNC;
            err_code_q <= ERR_NONE;
            err_cnt_q  <= '0;
            step_cnt_q <= '0;
            wrap_q     <= 1'b0;
            sel_prev_q <= 1'b0;
            i_prev_q   <= '0;
            n_prev_q   <= '0;
            k_prev_q   <= '0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            err_cnt_q  <= err_cnt_d;
            step_cnt_q <= step_cnt_d;
            wrap_q     <= model_wrap;
            sel_prev_q <= selector;
            i_prev_q   <= i;
            n_prev_q   <= n;
            k_prev_q   <= k;
        end
    end

    assign err        = (state_q == FAIL);
    assign err_code   = err_code_q;
    assign err_cnt    = err_cnt_q;
    assign step_cnt   = step_cnt_q;
    assign wrap_pulse = wrap_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_fib_seq_monitor.sv
// Bench for fib_seq_monitor: a golden-run vector table plus hand-written
// sequences for hold, fault injection, hold violation, mid-run reset and
// counter saturation (second instance with CNT_W=4).
module tb_fib_seq_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        selector = 1'b0;
    logic [10:0] i = 11'd0;
    logic [10:0] n = 11'd0;
    logic [10:0] k = 11'd1;

    logic        err, err_s;
    logic [2:0]  err_code, err_code_s;
    logic [15:0] err_cnt, step_cnt;
    logic [3:0]  err_cnt_s, step_cnt_s;
    logic        wrap_pulse, wrap_pulse_s;
    logic [1:0]  dbg_state, dbg_state_s;

    int checks = 0;
    int failures = 0;

    logic [10:0] p_i, p_n, p_k;
    logic [10:0] fib_k [22];

    typedef struct {
        logic        sel;
        logic [10:0] vi;
        logic [10:0] vn;
        logic [10:0] vk;
        logic        e_err;
        logic        e_wrap;
        int          e_step;
    } vec_t;
    vec_t gold [22];

    fib_seq_monitor dut (
        .clk(clk), .rst(rst), .selector(selector), .i(i), .n(n), .k(k),
        .err(err), .err_code(err_code), .err_cnt(err_cnt), .step_cnt(step_cnt),
        .wrap_pulse(wrap_pulse), .dbg_state(dbg_state)
    );

    fib_seq_monitor #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .selector(selector), .i(i), .n(n), .k(k),
        .err(err_s), .err_code(err_code_s), .err_cnt(err_cnt_s), .step_cnt(step_cnt_s),
        .wrap_pulse(wrap_pulse_s), .dbg_state(dbg_state_s)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one sample between edges; returns 1 time unit after the edge.
    task automatic drive(input logic s, input logic [10:0] vi, input logic [10:0] vn,
                         input logic [10:0] vk);
        @(negedge clk);
        selector = s;
        i = vi;
        n = vn;
        k = vk;
        @(posedge clk);
        #1;
    endtask

    // Producer contract, used to generate correct stimulus.
    task automatic prod_adv();
        if (p_i == 11'd21) begin
            p_i = 11'd0;
            p_n = 11'd0;
            p_k = 11'd1;
        end else begin
            p_i = p_i + 11'd1;
            {p_n, p_k} = {p_k, 11'(p_n + p_k)};
        end
    endtask

    task automatic prod_step(input logic s);
        drive(s, p_i, p_n, p_k);
        if (s) prod_adv();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_err_code"}, int'(err_code), 0);
        check({tag, "_err_cnt"}, int'(err_cnt), 0);
        check({tag, "_step_cnt"}, int'(step_cnt), 0);
        check({tag, "_wrap"}, int'(wrap_pulse), 0);
        check({tag, "_state"}, int'(dbg_state), 0);
        check({tag, "_sat_step"}, int'(step_cnt_s), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        selector = 1'b0;
        i = 11'd0;
        n = 11'd0;
        k = 11'd1;
        p_i = 11'd0;
        p_n = 11'd0;
        p_k = 11'd1;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_golden(input string tag);
        for (int r = 0; r < 22; r++) begin
            drive(gold[r].sel, gold[r].vi, gold[r].vn, gold[r].vk);
            check({tag, "_err"}, int'(err), int'(gold[r].e_err));
            check({tag, "_wrap"}, int'(wrap_pulse), int'(gold[r].e_wrap));
            check({tag, "_step"}, int'(step_cnt), gold[r].e_step);
            check({tag, "_state"}, int'(dbg_state), 1);
            check({tag, "_sat_step"}, int'(step_cnt_s), (gold[r].e_step > 15) ? 15 : gold[r].e_step);
        end
        // Sequence restarted: reset values must now match, and the pulse drops.
        drive(1'b0, 11'd0, 11'd0, 11'd1);
        check({tag, "_post_wrap"}, int'(wrap_pulse), 0);
        check({tag, "_post_err"}, int'(err), 0);
        check({tag, "_post_err_cnt"}, int'(err_cnt), 0);
        check({tag, "_post_step"}, int'(step_cnt), 22);
        check({tag, "_post_sat_step"}, int'(step_cnt_s), 15);
    endtask

    initial begin
        // k at index r is F(r+1) mod 2048
        fib_k = '{11'd1, 11'd1, 11'd2, 11'd3, 11'd5, 11'd8, 11'd13, 11'd21, 11'd34,
                  11'd55, 11'd89, 11'd144, 11'd233, 11'd377, 11'd610, 11'd987,
                  11'd1597, 11'd536, 11'd85, 11'd621, 11'd706, 11'd1327};
        for (int r = 0; r < 22; r++) begin
            gold[r].sel    = 1'b1;
            gold[r].vi     = 11'(r);
            gold[r].vn     = (r == 0) ? 11'd0 : fib_k[r-1];
            gold[r].vk     = fib_k[r];
            gold[r].e_err  = 1'b0;
            gold[r].e_wrap = (r == 21);
            gold[r].e_step = r + 1;
        end

        // Golden run
        do_reset();
        run_golden("golden");

        // Alternating selector: held cycles must not count or flag
        do_reset();
        for (int c = 0; c < 40; c++) begin
            prod_step((c % 2) == 0);
            check("hold_err", int'(err), 0);
        end
        check("hold_step", int'(step_cnt), 20);
        check("hold_err_cnt", int'(err_cnt), 0);
        check("hold_sat_step", int'(step_cnt_s), 15);
        prod_step(1'b1);
        check("hold_sat_stays", int'(step_cnt_s), 15);

        // Injected fault: k=7 at i=4 where 5 is expected
        do_reset();
        for (int c = 0; c < 4; c++) prod_step(1'b1);
        drive(1'b1, 11'd4, 11'd3, 11'd7);
        prod_adv();
        check("fault_err", int'(err), 1);
        check("fault_code", int'(err_code), 3);
        check("fault_state", int'(dbg_state), 2);
        check("fault_err_cnt", int'(err_cnt), 1);
        prod_step(1'b1);
        check("fault_clean_err_cnt", int'(err_cnt), 1);
        drive(1'b1, p_i + 11'd1, p_n, p_k);
        prod_adv();
        check("fault_later_err_cnt", int'(err_cnt), 2);
        check("fault_code_frozen", int'(err_code), 3);
        check("fault_still_fail", int'(dbg_state), 2);
        while (p_i != 11'd10) prod_step(1'b1);

        // Asynchronous reset mid-cycle while in FAIL, then a clean golden run
        i = p_i;
        n = p_n;
        k = p_k;
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        selector = 1'b0;
        i = 11'd0;
        n = 11'd0;
        k = 11'd1;
        rst = 1'b1;
        run_golden("regolden");

        // Hold violation: selector=0 at i=3, then i jumps to 4
        do_reset();
        for (int c = 0; c < 3; c++) prod_step(1'b1);
        prod_step(1'b0);
        check("hv_pre_err", int'(err), 0);
        drive(1'b0, 11'd4, 11'd3, 11'd5);
        check("hv_err", int'(err), 1);
        check("hv_code", int'(err_code), 4);
        check("hv_err_cnt", int'(err_cnt), 1);
        check("hv_state", int'(dbg_state), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
